// File: rtl/regression_pkg.sv
// Shared types and defaults for the regression sequencer.
package regression_pkg;

    localparam int unsigned CNT_W_DEF  = 11;
    localparam int unsigned N_COEF_DEF = 3;
    localparam int unsigned COEF_W     = 2;

    // Sequencer states; 3-bit encoding covers all eight.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_INVERT = 3'd4,
        ST_SOLVE  = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_e;

    // Width of a down-counter that must hold max(a,b)-1.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 3) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/regression_if.sv
// Sample stream and datapath control bundle between sequencer and datapath.
interface regression_if;

    logic                              smp_valid;
    logic                              smp_last;
    logic                              smp_ready;
    logic                              acc_clr;
    logic                              acc_en;
    logic                              inv_start;
    logic                              inv_done;
    logic                              coef_en;
    logic [regression_pkg::COEF_W-1:0] coef_idx;

    // Sequencer side.
    modport master (
        input  smp_valid,
        input  smp_last,
        input  inv_done,
        output smp_ready,
        output acc_clr,
        output acc_en,
        output inv_start,
        output coef_en,
        output coef_idx
    );

    // Producer / datapath side.
    modport slave (
        output smp_valid,
        output smp_last,
        output inv_done,
        input  smp_ready,
        input  acc_clr,
        input  acc_en,
        input  inv_start,
        input  coef_en,
        input  coef_idx
    );

endinterface

// File: rtl/regression_ctrl_timer.sv
// Loadable down-counter with zero flag; shared by the drain wait and inverse timeout.
module cycle_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over decrement; the count saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/regression_ctrl.sv
// Frame sequencer for the least-squares regression datapath:
// sample intake, accumulator gating, inverse launch and coefficient stepping.
module regression_ctrl
    import regression_pkg::*;
#(
    parameter int unsigned N_SAMPLES   = 1024,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned ACC_LAT     = 1,
    parameter int unsigned INV_TIMEOUT = 16,
    parameter int unsigned N_COEF      = N_COEF_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    regression_if.master     dp,
    output logic [CNT_W-1:0] smp_cnt,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned       TMR_W     = timer_width(ACC_LAT, INV_TIMEOUT);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(N_SAMPLES - 1);
    localparam logic [COEF_W-1:0] LAST_COEF = COEF_W'(N_COEF - 1);
    localparam logic [TMR_W-1:0]  DRAIN_LD  = TMR_W'(ACC_LAT - 1);
    localparam logic [TMR_W-1:0]  INV_LD    = TMR_W'(INV_TIMEOUT - 1);

    state_e              state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [COEF_W-1:0]   coef_idx_q,  coef_idx_d;
    logic                smp_ready_q, smp_ready_d;
    logic                acc_clr_q,   acc_clr_d;
    logic                inv_start_q, inv_start_d;
    logic                coef_en_q,   coef_en_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic                err_q,       err_d;

    logic                hs_c;
    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_val;
    logic                tmr_dec;
    logic                tmr_zero_c;

    assign hs_c = dp.smp_valid & smp_ready_q;

    // One timer: counts ACC_LAT in DRAIN, then the inverse timeout window in INVERT.
    cycle_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero_c   (tmr_zero_c)
    );

    // Next-state, counters and next-cycle outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        coef_idx_d  = coef_idx_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        tmr_dec     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (go) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                // An early last still gets counted; the frame then fails.
                if (hs_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = dp.smp_last ? ST_DRAIN : ST_ERR;
                    end else if (dp.smp_last) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_DRAIN: begin
                if (tmr_zero_c) state_d = ST_INVERT;
                else            tmr_dec = 1'b1;
            end
            ST_INVERT: begin
                // inv_done coinciding with the launch pulse belongs to an older request.
                if (!inv_start_q && dp.inv_done) begin
                    state_d = ST_SOLVE;
                end else if (tmr_zero_c) begin
                    state_d = ST_ERR;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_SOLVE: begin
                if (coef_idx_q == LAST_COEF) state_d = ST_DONE;
                else                         coef_idx_d = coef_idx_q + COEF_W'(1);
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                if (go) state_d = ST_CLEAR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Entry actions.
        if (state_d == ST_CLEAR) begin
            cnt_d = '0;
        end
        if (state_q == ST_ACCUM && state_d == ST_DRAIN) begin
            tmr_load = 1'b1;
            tmr_val  = DRAIN_LD;
        end
        if (state_q == ST_DRAIN && state_d == ST_INVERT) begin
            tmr_load = 1'b1;
            tmr_val  = INV_LD;
        end
        if (state_q != ST_SOLVE && state_d == ST_SOLVE) begin
            coef_idx_d = '0;
        end

        smp_ready_d = (state_d == ST_ACCUM);
        acc_clr_d   = (state_d == ST_CLEAR);
        inv_start_d = (state_q == ST_DRAIN) && (state_d == ST_INVERT);
        coef_en_d   = (state_d == ST_SOLVE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        err_d       = (state_d == ST_ERR);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            coef_idx_q  <= '0;
            smp_ready_q <= 1'b0;
            acc_clr_q   <= 1'b0;
            inv_start_q <= 1'b0;
            coef_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            coef_idx_q  <= coef_idx_d;
            smp_ready_q <= smp_ready_d;
            acc_clr_q   <= acc_clr_d;
            inv_start_q <= inv_start_d;
            coef_en_q   <= coef_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign dp.smp_ready = smp_ready_q;
    assign dp.acc_clr   = acc_clr_q;
    assign dp.acc_en    = hs_c;
    assign dp.inv_start = inv_start_q;
    assign dp.coef_en   = coef_en_q;
    assign dp.coef_idx  = coef_idx_q;
    assign smp_cnt      = cnt_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_regression_ctrl.sv
// Randomized frame-level bench for regression_ctrl against a timeline model.
module tb_regression_ctrl;

    localparam int unsigned N    = 4;
    localparam int unsigned CW   = 3;
    localparam int unsigned AL   = 1;
    localparam int unsigned TO   = 8;
    localparam int unsigned NC   = 3;
    localparam int          MAXC = 8192;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          go;
    logic [CW-1:0] smp_cnt;
    logic          busy;
    logic          done;
    logic          err;

    regression_if dif();

    regression_ctrl #(
        .N_SAMPLES   (N),
        .CNT_W       (CW),
        .ACC_LAT     (AL),
        .INV_TIMEOUT (TO),
        .N_COEF      (NC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .go      (go),
        .dp      (dif),
        .smp_cnt (smp_cnt),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] obs [MAXC];
    logic [31:0] expv [MAXC];
    bit          prev_err;
    int          prev_cnt;
    int          frame_no = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pack(input logic clr, input logic en, input logic rdy,
                                         input logic st, input logic cen, input logic [1:0] idx,
                                         input logic bsy, input logic dn, input logic er,
                                         input logic [15:0] cnt);
        return {cnt, 6'd0, clr, en, rdy, st, cen, (cen === 1'b1) ? idx : 2'b00, bsy, dn, er};
    endfunction

    function automatic logic [31:0] outs_now();
        return pack(dif.acc_clr, dif.acc_en, dif.smp_ready, dif.inv_start, dif.coef_en,
                    dif.coef_idx, busy, done, err, 16'(smp_cnt));
    endfunction

    always @(negedge clk) if (cyc < MAXC) obs[cyc] = outs_now();

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 good frame, 1 early last at handshake 'early', 2 no last on final sample,
    // 3 inverse never completes. dly: cycles from inv_start to inv_done.
    task automatic run_frame(input int gap, input int kind, input int early, input int vprob,
                             input int dly, input bit pre, input bit hold);
        int   start, g, a0, hend, s, e, hs, nfin;
        bit   fail, v, lst, term, acc, hit;
        logic clr, en, rdy, st, cen, bsy, dn, er;
        logic [1:0] idx;
        int   cnt;
        start = cyc + 1;
        g = start + gap;
        a0 = g + 2;
        hend = -1; s = -1; e = -1; hs = 0; nfin = 0;
        fail = (kind != 0);
        hit = 0;
        for (int c = start; c < start + 300; c++) begin
            step();
            v = 1'($urandom_range(0, 1));
            lst = 1'($urandom_range(0, 1));
            term = 0;
            acc = (c >= a0) && (hend < 0);
            if (acc) begin
                v = (vprob == 0) ? ((c - a0) % 3 == 0) : ($urandom_range(1, 100) <= vprob);
                lst = 0;
                if (v) begin
                    term = (kind == 1 && hs + 1 == early) || (hs + 1 == N);
                    lst = term && (kind != 2);
                end
            end
            dif.smp_valid = v;
            dif.smp_last = lst;
            go = (c == g) || (hold && kind == 0 && c > g && (e < 0 || c <= e));
            dif.inv_done = (s >= 0) && ((c == s && pre) || (kind != 3 && c == s + dly));

            clr = 0; en = 0; rdy = 0; st = 0; cen = 0; idx = 0; bsy = 0; dn = 0; er = 0;
            cnt = prev_cnt;
            if (c <= g) begin
                bsy = prev_err;
                er = prev_err;
            end else if (c == g + 1) begin
                clr = 1; bsy = 1; cnt = 0;
            end else if (acc) begin
                rdy = 1; bsy = 1; en = v; cnt = hs;
            end else begin
                bsy = 1;
                cnt = nfin;
                if (fail && c >= e) er = 1;
                else if (c == s) st = 1;
                else if (kind != 3 && c > s + dly && c < e) begin
                    cen = 1;
                    idx = 2'(c - s - dly - 1);
                end else if (kind != 3 && c == e) dn = 1;
            end
            expv[c] = pack(clr, en, rdy, st, cen, idx, bsy, dn, er, 16'(cnt));

            if (acc && v) begin
                hs++;
                if (term) begin
                    hend = c;
                    nfin = hs;
                    if (kind == 1 || kind == 2) begin
                        e = c + 1;
                    end else begin
                        s = c + AL + 1;
                        e = (kind == 3) ? s + TO : s + dly + NC + 1;
                    end
                end
            end
            if (c == e) begin
                hit = 1;
                break;
            end
        end
        @(negedge clk);
        #1;
        if (!hit) begin
            check($sformatf("f%0d_no_end", frame_no), 32'd0, 32'd1);
        end else begin
            for (int c = start; c <= e; c++)
                check($sformatf("f%0d_k%0d_c%0d", frame_no, kind, c - start), obs[c], expv[c]);
        end
        prev_err = fail;
        prev_cnt = nfin;
        frame_no++;
    endtask

    // Reset while two samples into a frame.
    task automatic reset_mid_accum();
        go = 0; dif.smp_valid = 0; dif.smp_last = 0; dif.inv_done = 0;
        step();
        go = 1;
        step();
        go = 0;
        step();
        dif.smp_valid = 1;
        step();
        step();
        #2;
        check("rst_mid_cnt", 32'(smp_cnt), 32'd2);
        check("rst_mid_busy", 32'(busy), 32'd1);
        rst_n = 0;
        #1;
        check("rst_mid_async", outs_now(), 32'd0);
        step();
        step();
        check("rst_mid_hold", outs_now(), 32'd0);
        rst_n = 1;
        dif.smp_valid = 0;
        prev_err = 0;
        prev_cnt = 0;
    endtask

    initial begin
        rst_n = 1; go = 0;
        dif.smp_valid = 0; dif.smp_last = 0; dif.inv_done = 0;
        prev_err = 0; prev_cnt = 0;
        #1 rst_n = 0;
        #2 check("reset_outs", outs_now(), 32'd0);
        step();
        step();
        rst_n = 1;
        step();
        check("reset_idle", outs_now(), 32'd0);

        run_frame(1, 0, 0, 100, 3, 0, 0);
        run_frame(0, 0, 0, 0, 2, 0, 0);
        run_frame(2, 1, 2, 100, 1, 0, 0);
        run_frame(1, 0, 0, 100, 3, 0, 0);
        run_frame(0, 3, 0, 100, 1, 1, 0);
        run_frame(2, 0, 0, 70, TO - 1, 1, 0);
        reset_mid_accum();
        run_frame(1, 0, 0, 100, 3, 0, 0);
        run_frame(1, 0, 0, 100, 1, 0, 1);
        run_frame(0, 0, 0, 100, 2, 0, 0);
        run_frame(0, 2, 0, 100, 1, 0, 0);
        run_frame(1, 1, 1, 100, 1, 0, 0);
        run_frame(0, 1, N - 1, 60, 1, 0, 0);

        for (int i = 0; i < 30; i++) begin
            int r, k;
            r = $urandom_range(0, 99);
            k = (r < 55) ? 0 : (r < 70) ? 1 : (r < 85) ? 2 : 3;
            run_frame($urandom_range(0, 3), k, $urandom_range(1, N - 1), $urandom_range(30, 100),
                      $urandom_range(1, TO - 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        go = 0; dif.smp_valid = 0; dif.inv_done = 0;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
